// File: rtl/iomem_yanitlayici_if.sv
// iomem valid/ready bus bundle shared by the processor-side initiator and the responder.
// ready/rdata flow back from the target; everything else flows from the initiator.
interface iomem_yanitlayici_if;
  logic        valid;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;

  modport master (output valid, output wstrb, output addr, output wdata,
                  input  ready, input  rdata);
  modport slave  (input  valid, input  wstrb, input  addr, input  wdata,
                  output ready, output rdata);
endinterface

// File: rtl/iomem_yanitlayici.sv
// iomem target responder: word-addressed scratch RAM with programmable wait states.
// Every request is answered, out-of-range ones with an error pulse and a saturating count.
module iomem_yanitlayici #(
  parameter logic [31:0] ADRES_TABANI = 32'h4000_0000,
  parameter int          DERINLIK     = 256,
  parameter int          GECIKME      = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  iomem_yanitlayici_if.slave   iomem,
  output logic                 hata_o,
  output logic [7:0]           hata_sayaci_o
);

  localparam int          AW        = $clog2(DERINLIK);
  localparam logic [31:0] PENCERE   = 32'(4 * DERINLIK);
  localparam logic [3:0]  GECIKME_Y = 4'(GECIKME);

  typedef enum logic [1:0] {BOSTA, BEKLE, YANIT} durum_t;

  durum_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d;
  logic        hata_q, hata_d;
  logic [7:0]  sayac_q, sayac_d;

  logic [31:0] mem [DERINLIK];

  logic [31:0] req_addr, req_wdata, offset;
  logic [3:0]  req_wstrb;
  logic        in_range, enter_yanit, mem_we;
  logic [AW-1:0] word_idx;

  // With zero wait states the access executes on the accepting edge, so the
  // live bus fields are used there instead of the not-yet-latched copies.
  always_comb begin
    req_addr  = addr_q;
    req_wdata = wdata_q;
    req_wstrb = wstrb_q;
    if (state_q == BOSTA) begin
      req_addr  = iomem.addr;
      req_wdata = iomem.wdata;
      req_wstrb = iomem.wstrb;
    end
    offset   = req_addr - ADRES_TABANI;
    in_range = (req_addr >= ADRES_TABANI) && (offset < PENCERE);
    word_idx = offset[AW+1:2];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    enter_yanit = 1'b0;
    case (state_q)
      BOSTA: begin
        if (iomem.valid) begin
          addr_d  = iomem.addr;
          wdata_d = iomem.wdata;
          wstrb_d = iomem.wstrb;
          cnt_d   = GECIKME_Y;
          if (GECIKME == 0) begin
            state_d     = YANIT;
            enter_yanit = 1'b1;
          end else begin
            state_d = BEKLE;
          end
        end
      end
      BEKLE: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d     = YANIT;
          enter_yanit = 1'b1;
        end
      end
      YANIT:   state_d = BOSTA;
      default: state_d = BOSTA;
    endcase
  end

  always_comb begin
    ready_d = enter_yanit;
    hata_d  = enter_yanit && !in_range;
    rdata_d = rdata_q;
    sayac_d = sayac_q;
    if (enter_yanit && (req_wstrb == 4'd0)) begin
      rdata_d = in_range ? mem[word_idx] : 32'h0000_0000;
    end
    if (enter_yanit && !in_range && (sayac_q != 8'hFF)) begin
      sayac_d = sayac_q + 8'd1;
    end
    // Reset held across an edge must not let a zero-wait request slip a write in.
    mem_we = enter_yanit && in_range && (req_wstrb != 4'd0) && rst_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= BOSTA;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
      ready_q <= 1'b0;
      rdata_q <= 32'd0;
      hata_q  <= 1'b0;
      sayac_q <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      hata_q  <= hata_d;
      sayac_q <= sayac_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (req_wstrb[i]) mem[word_idx][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

  assign iomem.ready   = ready_q;
  assign iomem.rdata   = rdata_q;
  assign hata_o        = hata_q;
  assign hata_sayaci_o = sayac_q;

endmodule

// File: tb/tb_iomem_yanitlayici.sv
// Directed bench for iomem_yanitlayici: three responders with wait states 2, 0 and 5
// share one clock and reset; a select picks which one the bus master talks to.
module tb_iomem_yanitlayici;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  sel;
  logic        m_valid;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr, m_wdata;

  logic        rdy, hata;
  logic [31:0] rdata;
  logic [7:0]  sayac;
  logic        hata_g2, hata_g0, hata_g5;
  logic [7:0]  sayac_g2, sayac_g0, sayac_g5;

  int errors = 0;
  int checks = 0;

  iomem_yanitlayici_if bus_g2 ();
  iomem_yanitlayici_if bus_g0 ();
  iomem_yanitlayici_if bus_g5 ();

  iomem_yanitlayici #(.ADRES_TABANI(32'h4000_0000), .DERINLIK(256), .GECIKME(2)) dut_g2 (
    .clk_i(clk), .rst_i(rst_n), .iomem(bus_g2), .hata_o(hata_g2), .hata_sayaci_o(sayac_g2));
  iomem_yanitlayici #(.ADRES_TABANI(32'h4000_0000), .DERINLIK(256), .GECIKME(0)) dut_g0 (
    .clk_i(clk), .rst_i(rst_n), .iomem(bus_g0), .hata_o(hata_g0), .hata_sayaci_o(sayac_g0));
  iomem_yanitlayici #(.ADRES_TABANI(32'h4000_0000), .DERINLIK(256), .GECIKME(5)) dut_g5 (
    .clk_i(clk), .rst_i(rst_n), .iomem(bus_g5), .hata_o(hata_g5), .hata_sayaci_o(sayac_g5));

  assign bus_g2.valid = m_valid && (sel == 2'd0);
  assign bus_g0.valid = m_valid && (sel == 2'd1);
  assign bus_g5.valid = m_valid && (sel == 2'd2);
  assign bus_g2.wstrb = m_wstrb;
  assign bus_g0.wstrb = m_wstrb;
  assign bus_g5.wstrb = m_wstrb;
  assign bus_g2.addr  = m_addr;
  assign bus_g0.addr  = m_addr;
  assign bus_g5.addr  = m_addr;
  assign bus_g2.wdata = m_wdata;
  assign bus_g0.wdata = m_wdata;
  assign bus_g5.wdata = m_wdata;

  always_comb begin
    case (sel)
      2'd1:    begin rdy = bus_g0.ready; rdata = bus_g0.rdata; hata = hata_g0; sayac = sayac_g0; end
      2'd2:    begin rdy = bus_g5.ready; rdata = bus_g5.rdata; hata = hata_g5; sayac = sayac_g5; end
      default: begin rdy = bus_g2.ready; rdata = bus_g2.rdata; hata = hata_g2; sayac = sayac_g2; end
    endcase
  end

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One transaction: offer the request, then scramble the bus and drop valid right
  // after acceptance so only the latched copy can be used. Returns wait cycles
  // (ready seen after the accepting edge), the completion data/error and ready one
  // cycle later. Called and returns at 1ns after a rising edge.
  task automatic applyStimulus(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                               output int lat, output logic [31:0] rd, output logic err,
                               output logic rdy_after);
    m_valid = 1'b1; m_addr = a; m_wstrb = s; m_wdata = d;
    @(posedge clk); #1;
    m_valid = 1'b0; m_addr = 32'h0; m_wstrb = 4'hF; m_wdata = 32'hFFFF_FFFF;
    lat = 0;
    while (!rdy && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!rdy) checkOutput("ready_timeout", {31'd0, rdy}, 32'd1);
    rd  = rdata;
    err = hata;
    @(posedge clk); #1;
    rdy_after = rdy;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          lat, cyc, prev, idx, pulses;
    logic [31:0] rd;
    logic        err, ra;
    logic [31:0] b2b_addr [4];
    logic [31:0] b2b_val  [4];

    b2b_addr = '{32'h4000_0020, 32'h4000_0024, 32'h4000_0028, 32'h4000_002C};
    b2b_val  = '{32'h0123_4567, 32'h89AB_CDEF, 32'hFEDC_BA98, 32'h7654_3210};

    rst_n = 1'b0; sel = 2'd0; m_valid = 1'b0; m_wstrb = 4'd0; m_addr = 32'd0; m_wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ready",  {31'd0, rdy}, 32'd0);
    checkOutput("rst_rdata",  rdata, 32'd0);
    checkOutput("rst_hata",   {31'd0, hata}, 32'd0);
    checkOutput("rst_sayac",  {24'd0, sayac}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Wait states 2: write then read, ready three cycles after acceptance.
    sel = 2'd0;
    applyStimulus(32'h4000_0010, 4'hF, 32'hCAFE_F00D, lat, rd, err, ra);
    checkOutput("wr_latency", lat + 1, 32'd3);
    checkOutput("wr_hata", {31'd0, err}, 32'd0);
    checkOutput("wr_single_ready", {31'd0, ra}, 32'd0);
    applyStimulus(32'h4000_0010, 4'h0, 32'h0, lat, rd, err, ra);
    checkOutput("rd_latency", lat + 1, 32'd3);
    checkOutput("rd_data", rd, 32'hCAFE_F00D);
    checkOutput("rd_hata", {31'd0, err}, 32'd0);

    // Byte strobes, plus a marker in the last word of the window.
    applyStimulus(32'h4000_0000, 4'hF, 32'h1122_3344, lat, rd, err, ra);
    applyStimulus(32'h4000_0000, 4'b0101, 32'hAABB_CCDD, lat, rd, err, ra);
    applyStimulus(32'h4000_03FC, 4'hF, 32'h5566_7788, lat, rd, err, ra);
    applyStimulus(32'h4000_0000, 4'h0, 32'h0, lat, rd, err, ra);
    checkOutput("strobe_data", rd, 32'h11BB_33DD);

    // Out-of-range read just below the window and write just above it.
    applyStimulus(32'h3FFF_FFFC, 4'h0, 32'h0, lat, rd, err, ra);
    checkOutput("oor_rd_data", rd, 32'h0);
    checkOutput("oor_rd_hata", {31'd0, err}, 32'd1);
    checkOutput("oor_rd_latency", lat + 1, 32'd3);
    applyStimulus(32'h4000_0400, 4'hF, 32'hDEAD_BEEF, lat, rd, err, ra);
    checkOutput("oor_wr_hata", {31'd0, err}, 32'd1);
    checkOutput("oor_hata_pulse", {31'd0, hata}, 32'd0);
    checkOutput("oor_sayac", {24'd0, sayac}, 32'd2);
    applyStimulus(32'h4000_0000, 4'h0, 32'h0, lat, rd, err, ra);
    checkOutput("oor_word0_kept", rd, 32'h11BB_33DD);
    applyStimulus(32'h4000_03FC, 4'h0, 32'h0, lat, rd, err, ra);
    checkOutput("oor_word255_kept", rd, 32'h5566_7788);
    applyStimulus(32'h4000_0004, 4'hF, 32'h0F0F_0F0F, lat, rd, err, ra);
    checkOutput("wr_rdata_hold", rd, 32'h5566_7788);

    // Zero wait states: preload, then four reads with valid held high.
    sel = 2'd1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(b2b_addr[i], 4'hF, b2b_val[i], lat, rd, err, ra);
    end
    checkOutput("g0_latency", lat + 1, 32'd1);
    m_valid = 1'b1; m_wstrb = 4'h0; m_addr = b2b_addr[0];
    idx = 0; cyc = 0; prev = 0;
    while (idx < 4 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (rdy) begin
        checkOutput($sformatf("b2b_data%0d", idx), rdata, b2b_val[idx]);
        if (idx > 0) checkOutput("b2b_spacing", cyc - prev, 32'd2);
        prev = cyc;
        idx++;
        if (idx < 4) m_addr = b2b_addr[idx];
        else m_valid = 1'b0;
      end
    end
    if (idx < 4) checkOutput("b2b_timeout", idx, 32'd4);
    m_valid = 1'b0;
    @(posedge clk); #1;

    // Wait states 5: reset two cycles into a read aborts it at once.
    sel = 2'd2;
    applyStimulus(32'h5000_0000, 4'h0, 32'h0, lat, rd, err, ra);
    applyStimulus(32'h4000_0040, 4'hF, 32'h1234_5678, lat, rd, err, ra);
    applyStimulus(32'h4000_0040, 4'h0, 32'h0, lat, rd, err, ra);
    checkOutput("g5_latency", lat + 1, 32'd6);
    checkOutput("g5_pre_data", rd, 32'h1234_5678);
    checkOutput("g5_pre_sayac", {24'd0, sayac}, 32'd1);
    m_valid = 1'b1; m_addr = 32'h4000_0040; m_wstrb = 4'h0;
    @(posedge clk); #1;
    m_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_ready", {31'd0, rdy}, 32'd0);
    checkOutput("mid_rst_rdata", rdata, 32'd0);
    checkOutput("mid_rst_sayac", {24'd0, sayac}, 32'd0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (rdy) pulses++;
    end
    checkOutput("aborted_no_ready", pulses, 32'd0);
    applyStimulus(32'h4000_0044, 4'hF, 32'h0BAD_F00D, lat, rd, err, ra);
    applyStimulus(32'h4000_0044, 4'h0, 32'h0, lat, rd, err, ra);
    checkOutput("post_rst_latency", lat + 1, 32'd6);
    checkOutput("post_rst_data", rd, 32'h0BAD_F00D);

    // Saturation of the error counter on the zero-wait responder.
    sel = 2'd1;
    for (int i = 1; i <= 300; i++) begin
      applyStimulus(32'h3000_0000, 4'h0, 32'h0, lat, rd, err, ra);
      if (i == 254) checkOutput("sat_254", {24'd0, sayac}, 32'd254);
    end
    checkOutput("sat_300", {24'd0, sayac}, 32'd255);
    checkOutput("sat_hata", {31'd0, err}, 32'd1);

    // Valid dropped (and bus scrambled) during the wait: the latched read still completes.
    sel = 2'd0;
    applyStimulus(32'h4000_0100, 4'hF, 32'h1357_9BDF, lat, rd, err, ra);
    applyStimulus(32'h4000_0100, 4'h0, 32'h0, lat, rd, err, ra);
    checkOutput("drop_latency", lat + 1, 32'd3);
    checkOutput("drop_data", rd, 32'h1357_9BDF);
    checkOutput("drop_single_ready", {31'd0, ra}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
